// File: rtl/spi_to_memory_bus.sv
// SPI mode-0 slave that turns a command byte {rw, addr[6:0]} plus data bytes into single-cycle membus strobes.
// Optional burst mode (address auto-increment per data byte) is enabled by defining SPI_BRIDGE_AUTOINC_EN.
module spi_to_memory_bus #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_BYTE   = 8'h00
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       SPI_SCK,
  input  logic       SPI_CS_N,
  input  logic       SPI_MOSI,
  output logic       SPI_MISO,
  output logic       membus_read_req_o,
  output logic       membus_write_req_o,
  output logic [6:0] membus_addr_o,
  output logic [7:0] membus_data_o,
  input  logic [7:0] membus_data_i,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_FETCH  = 3'd2,
    ST_DATA   = 3'd3,
    ST_IGNORE = 3'd4
  } state_t;

`ifdef SPI_BRIDGE_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_d;

  logic       w_sck;
  logic       w_cs_n;
  logic       w_mosi;
  logic       w_sck_rise;
  logic       w_sck_fall;
  logic       w_byte_done;
  logic [7:0] w_rx_byte;

  state_t     r_state,      w_state_n;
  logic [2:0] r_bit_cnt,    w_bit_cnt_n;
  logic [6:0] r_rx_shreg,   w_rx_shreg_n;
  logic [7:0] r_tx_shreg,   w_tx_shreg_n;
  logic [6:0] r_addr,       w_addr_n;
  logic       r_rw,         w_rw_n;
  logic [7:0] r_data_o,     w_data_o_n;
  logic       r_read_req,   w_read_req_n;
  logic       r_write_req,  w_write_req_n;

  // CS_N synchroniser resets to "deselected" so reset never looks like a new transaction.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sck_d     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of statement order.
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], SPI_SCK};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], SPI_CS_N};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
      r_sck_d     <= w_sck;
    end
  end

  assign w_sck       = r_sck_sync[SYNC_STAGES-1];
  assign w_cs_n      = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_sck_rise  = w_sck & ~r_sck_d;
  assign w_sck_fall  = ~w_sck & r_sck_d;
  assign w_rx_byte   = {r_rx_shreg, w_mosi};
  assign w_byte_done = (r_state != ST_IDLE) && w_sck_rise && (r_bit_cnt == 3'd7);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_rx_shreg  <= '0;
      r_tx_shreg  <= '0;
      r_addr      <= '0;
      r_rw        <= 1'b0;
      r_data_o    <= '0;
      r_read_req  <= 1'b0;
      r_write_req <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_bit_cnt   <= w_bit_cnt_n;
      r_rx_shreg  <= w_rx_shreg_n;
      r_tx_shreg  <= w_tx_shreg_n;
      r_addr      <= w_addr_n;
      r_rw        <= w_rw_n;
      r_data_o    <= w_data_o_n;
      r_read_req  <= w_read_req_n;
      r_write_req <= w_write_req_n;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_n     = r_state;
    w_bit_cnt_n   = r_bit_cnt;
    w_rx_shreg_n  = r_rx_shreg;
    w_tx_shreg_n  = r_tx_shreg;
    w_addr_n      = r_addr;
    w_rw_n        = r_rw;
    w_data_o_n    = r_data_o;
    w_read_req_n  = 1'b0;
    w_write_req_n = 1'b0;

    // The fall right after a byte boundary (bit_cnt==0) must not shift, so the new MSB stays on MISO.
    if (r_state != ST_IDLE) begin
      if (w_sck_rise) begin
        w_bit_cnt_n  = r_bit_cnt + 3'd1;
        w_rx_shreg_n = w_rx_byte[6:0];
      end else if (w_sck_fall && (r_bit_cnt != 3'd0)) begin
        w_tx_shreg_n = {r_tx_shreg[6:0], 1'b0};
      end
    end

    case (r_state)
      ST_IDLE: begin
        w_tx_shreg_n = IDLE_BYTE;
        w_bit_cnt_n  = '0;
        w_rx_shreg_n = '0;
        if (!w_cs_n) w_state_n = ST_CMD;
      end
      ST_CMD: begin
        if (w_byte_done) begin
          w_addr_n     = w_rx_byte[6:0];
          w_rw_n       = w_rx_byte[7];
          w_tx_shreg_n = IDLE_BYTE;
          if (w_rx_byte[7]) begin
            w_read_req_n = 1'b1;
            w_state_n    = ST_FETCH;
          end else begin
            w_state_n    = ST_DATA;
          end
        end
      end
      ST_FETCH: begin
        // First FETCH cycle carries the strobe; slave data is valid on the following one.
        if (!r_read_req) begin
          w_tx_shreg_n = membus_data_i;
          w_state_n    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (AUTOINC && r_write_req) w_addr_n = r_addr + 7'd1;
        if (w_byte_done) begin
          if (r_rw) begin
            if (AUTOINC) begin
              w_addr_n     = r_addr + 7'd1;
              w_read_req_n = 1'b1;
              w_state_n    = ST_FETCH;
            end else begin
              w_tx_shreg_n = IDLE_BYTE;
              w_state_n    = ST_IGNORE;
            end
          end else begin
            w_data_o_n    = w_rx_byte;
            w_write_req_n = 1'b1;
            w_tx_shreg_n  = IDLE_BYTE;
            w_state_n     = AUTOINC ? ST_DATA : ST_IGNORE;
          end
        end
      end
      ST_IGNORE: begin
        if (w_byte_done) w_tx_shreg_n = IDLE_BYTE;
      end
      default: w_state_n = ST_IDLE;
    endcase

    // Deselect wins over everything, including a byte completing on the same cycle.
    if (w_cs_n && (r_state != ST_IDLE)) begin
      w_state_n     = ST_IDLE;
      w_addr_n      = r_addr;
      w_rw_n        = r_rw;
      w_data_o_n    = r_data_o;
      w_read_req_n  = 1'b0;
      w_write_req_n = 1'b0;
    end
  end

  assign SPI_MISO           = r_tx_shreg[7];
  assign membus_read_req_o  = r_read_req;
  assign membus_write_req_o = r_write_req;
  assign membus_addr_o      = r_addr;
  assign membus_data_o      = r_data_o;
  assign dbg_state          = r_state;

endmodule

// File: tb/tb_spi_to_memory_bus.sv
// Self-checking bench for spi_to_memory_bus: directed cases plus random transactions against a
// transaction-level model (memory array + expected strobe list per transaction).
module tb_spi_to_memory_bus;

  localparam int         SYNC_STAGES = 2;
  localparam logic [7:0] IDLE_BYTE   = 8'h00;
  localparam int         HALF        = 6;     // SCK half period in clk cycles (SCK = clk/12)
  localparam int         CLK_PERIOD  = 10;
  localparam int         NUM_RAND    = 200;

`ifdef SPI_BRIDGE_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_i;
  logic       SPI_SCK;
  logic       SPI_CS_N;
  logic       SPI_MOSI;
  logic       SPI_MISO;
  logic       membus_read_req_o;
  logic       membus_write_req_o;
  logic [6:0] membus_addr_o;
  logic [7:0] membus_data_o;
  logic [7:0] membus_data_i = 8'h00;
  logic [2:0] dbg_state;

  always #(CLK_PERIOD / 2) clk = ~clk;

  spi_to_memory_bus #(
    .SYNC_STAGES (SYNC_STAGES),
    .IDLE_BYTE   (IDLE_BYTE)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .SPI_SCK            (SPI_SCK),
    .SPI_CS_N           (SPI_CS_N),
    .SPI_MOSI           (SPI_MOSI),
    .SPI_MISO           (SPI_MISO),
    .membus_read_req_o  (membus_read_req_o),
    .membus_write_req_o (membus_write_req_o),
    .membus_addr_o      (membus_addr_o),
    .membus_data_o      (membus_data_o),
    .membus_data_i      (membus_data_i),
    .dbg_state          (dbg_state)
  );

  // Slave stub: registered read data one cycle after the strobe, writes land in its own array.
  logic [7:0] init_mem  [128];
  logic [7:0] stub_mem  [128];
  logic [7:0] model_mem [128];
  logic       load_mem = 1'b0;

  always @(posedge clk) begin
    if (load_mem) stub_mem <= init_mem;
    else if (membus_write_req_o) stub_mem[membus_addr_o] <= membus_data_o;
    if (membus_read_req_o) membus_data_i <= stub_mem[membus_addr_o];
  end

  // Bus monitor: log every strobe cycle and any read/write overlap.
  typedef struct {
    logic       wr;
    logic [6:0] addr;
    logic [7:0] data;
    longint     t;
  } strobe_t;

  strobe_t bus_q[$];
  int      overlap_cnt = 0;

  always @(negedge clk) begin
    if (membus_read_req_o && membus_write_req_o) overlap_cnt <= overlap_cnt + 1;
    if (membus_read_req_o)  bus_q.push_back('{1'b0, membus_addr_o, 8'h00, longint'($time)});
    if (membus_write_req_o) bus_q.push_back('{1'b1, membus_addr_o, membus_data_o, longint'($time)});
  end

  int         errors = 0;
  int         checks = 0;
  longint     last_rise_t = 0;
  logic [7:0] txd [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Host side of SPI mode 0: MOSI set while SCK low, MISO sampled at the rising edge.
  task automatic spi_bits(input logic [7:0] b, input int nbits, output logic [7:0] rb);
    rb = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      SPI_MOSI = b[i];
      wait_clk(HALF);
      rb[i]       = SPI_MISO;
      SPI_SCK     = 1'b1;
      last_rise_t = longint'($time);
      wait_clk(HALF);
      SPI_SCK     = 1'b0;
    end
  endtask

  // One complete transaction: command byte + n data bytes from txd[], then compare with the model.
  task automatic run_txn(input string tag, input logic [7:0] cmd, input int n);
    logic [7:0] rb;
    logic [7:0] miso_b [5];
    logic [6:0] a;
    int         base;
    int         nexp;
    base = bus_q.size();
    SPI_CS_N = 1'b0;
    wait_clk(HALF);
    spi_bits(cmd, 8, rb);
    miso_b[0] = rb;
    for (int k = 0; k < n; k++) begin
      spi_bits(txd[k], 8, rb);
      miso_b[k+1] = rb;
    end
    wait_clk(4);
    SPI_CS_N = 1'b1;
    wait_clk(HALF);

    a = cmd[6:0];
    check({tag, " miso_cmd_byte"}, 32'(miso_b[0]), 32'(IDLE_BYTE));
    if (cmd[7]) begin
      nexp = AUTOINC ? n + 1 : 1;
      for (int k = 0; k < n; k++)
        check({tag, " miso_data_byte"}, 32'(miso_b[k+1]),
              32'((AUTOINC || k == 0) ? model_mem[7'(a + k)] : IDLE_BYTE));
    end else begin
      nexp = AUTOINC ? n : 1;
    end
    check({tag, " strobe_count"}, 32'(bus_q.size() - base), 32'(nexp));
    for (int k = 0; k < nexp && base + k < bus_q.size(); k++) begin
      check({tag, " strobe_is_write"}, 32'(bus_q[base+k].wr), 32'(!cmd[7]));
      check({tag, " strobe_addr"}, 32'(bus_q[base+k].addr), 32'(7'(a + k)));
      if (!cmd[7]) check({tag, " write_data"}, 32'(bus_q[base+k].data), 32'(txd[k]));
    end
    if (!cmd[7])
      for (int k = 0; k < nexp; k++) model_mem[7'(a + k)] = txd[k];
    check({tag, " state_idle_after"}, 32'(dbg_state), 32'd0);
  endtask

  initial begin
    logic [7:0] rb;
    int         base;
    bit         found;

    rst_i    = 1'b1;
    SPI_SCK  = 1'b0;
    SPI_CS_N = 1'b1;
    SPI_MOSI = 1'b0;
    for (int i = 0; i < 128; i++) init_mem[i] = 8'($urandom);
    init_mem[16] = 8'h34;
    init_mem[17] = 8'h12;
    model_mem    = init_mem;
    load_mem     = 1'b1;
    wait_clk(3);
    load_mem = 1'b0;
    rst_i    = 1'b0;
    wait_clk(2);
    check("reset_outputs", 32'({membus_read_req_o, membus_write_req_o, membus_addr_o,
                                membus_data_o, SPI_MISO}), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);

    // Read of the CO2 low byte.
    txd[0] = 8'h00;
    run_txn("t1_read_0x10", 8'h90, 1);

    // Single write; strobe lands one clk after the synchronised 16th rise.
    txd[0] = 8'hA5;
    base   = bus_q.size();
    run_txn("t2_write_0x05", 8'h05, 1);
    if (bus_q.size() > base)
      check("t2_strobe_latency", 32'(bus_q[base].t - last_rise_t), 32'((SYNC_STAGES + 1) * CLK_PERIOD));

    // Write aborted after 5 bits of the data byte.
    base     = bus_q.size();
    SPI_CS_N = 1'b0;
    wait_clk(HALF);
    spi_bits(8'h20, 8, rb);
    spi_bits(8'hC3, 5, rb);
    wait_clk(2);
    SPI_CS_N = 1'b1;
    wait_clk(HALF);
    check("t3_no_strobe", 32'(bus_q.size() - base), 32'd0);
    check("t3_state_idle", 32'(dbg_state), 32'd0);
    txd[0] = 8'h5A;
    run_txn("t3_followup_write", 8'h20, 1);

    // Read at 0x7F with three data bytes (wraps to 0x00 in burst mode).
    txd[0] = 8'h00; txd[1] = 8'h00; txd[2] = 8'h00;
    run_txn("t4_read_wrap", 8'hFF, 3);

    // Reset pulsed while the bridge waits for read data.
    base     = bus_q.size();
    found    = 1'b0;
    SPI_CS_N = 1'b0;
    wait_clk(HALF);
    fork
      spi_bits(8'h90, 8, rb);
      begin
        for (int i = 0; i < 200; i++) begin
          @(negedge clk);
          if (dbg_state === 3'd2) begin
            found = 1'b1;
            break;
          end
        end
        if (found) begin
          rst_i = 1'b1;
          @(negedge clk);
          check("t5_outputs_after_reset", 32'({membus_read_req_o, membus_write_req_o, membus_addr_o,
                                               membus_data_o, SPI_MISO}), 32'd0);
          check("t5_state_after_reset", 32'(dbg_state), 32'd0);
          rst_i = 1'b0;
        end
      end
    join
    check("t5_fetch_reached", 32'(found), 32'd1);
    wait_clk(2);
    SPI_CS_N = 1'b1;
    wait_clk(HALF);
    check("t5_single_strobe", 32'(bus_q.size() - base), 32'd1);
    check("t5_state_idle", 32'(dbg_state), 32'd0);
    txd[0] = 8'h00;
    run_txn("t5_followup_read", 8'h91, 1);

    // Random traffic against the model.
    for (int r = 0; r < NUM_RAND; r++) begin
      logic [7:0] cmd;
      int         n;
      cmd = 8'($urandom);
      n   = int'($urandom_range(1, 2));
      for (int k = 0; k < 4; k++) txd[k] = 8'($urandom);
      run_txn("rand", cmd, n);
    end

    check("no_strobe_overlap", 32'(overlap_cnt), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
